// File: rtl/gpo_led_driver.sv
// gpo_led_driver: timed output stage between the GPO register bits and the
// board LED pads. Each channel gets a minimum-on pulse stretcher so short
// software pulses stay visible, and all channels share one free-running PWM
// counter that sets a fixed brightness.
//
// Optional feature macro: GPO_LED_STRETCH_EN
//   defined   - per-channel IDLE/ON/HOLD stretcher with a reload counter
//   undefined - active is gpo_q delayed one cycle (same latency, no stretch,
//               STRETCH_CYCLES only takes part in the parameter check)
//
// Latency: gpo_i change sampled into gpo_q, state/active one edge later,
// led_o registered one edge after that.

module gpo_led_driver #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PWM_BITS       = 8,
  parameter int unsigned DUTY           = 64,
  parameter int unsigned STRETCH_CYCLES = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] gpo_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] led_o,
  output logic [NUM_CH-1:0] active_o
);

  // Compare is one bit wider than the counter so DUTY >= 2**PWM_BITS
  // means "always on while active".
  localparam int unsigned CMP_W = PWM_BITS + 1;
  localparam logic [CMP_W-1:0] DUTY_CMP = CMP_W'(DUTY);

  // A zero stretch would leave a channel unable to report any activity.
  if (STRETCH_CYCLES == 0) begin : g_stretch_check
    $error("gpo_led_driver: STRETCH_CYCLES must be at least 1");
  end

  logic [NUM_CH-1:0]   gpo_q;
  logic [NUM_CH-1:0]   active_c;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                pwm_on_c;
  logic [NUM_CH-1:0]   led_q;

  // Input register: one cycle of isolation from the GPO peripheral pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gpo_q <= '0;
    end else begin
      gpo_q <= gpo_i;
    end
  end

  // Shared PWM counter, parked at zero while LEDs are globally disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  // On-phase of the PWM period.
  assign pwm_on_c = ({1'b0, pwm_cnt_q} < DUTY_CMP);

`ifdef GPO_LED_STRETCH_EN

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int unsigned CNT_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH_CYCLES - 1);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stretcher state register; reset aborts any stretch in progress.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Stretch counts from the rising edge; a re-rise in HOLD restarts it.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_IDLE: begin
          if (gpo_q[ch]) begin
            state_d = ST_ON;
            cnt_d   = RELOAD;
          end
        end
        ST_ON: begin
          if (gpo_q[ch]) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end else if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (gpo_q[ch]) begin
            state_d = ST_ON;
            cnt_d   = RELOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign active_c[ch] = (state_q != ST_IDLE);
  end

`else

  logic [NUM_CH-1:0] active_q;

  // Without stretching, active simply follows gpo_q one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= '0;
    end else begin
      active_q <= gpo_q;
    end
  end

  assign active_c = active_q;

`endif

  // LED drive: active channels gated by the PWM phase and the global enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q <= '0;
    end else if (en_i) begin
      led_q <= active_c & {NUM_CH{pwm_on_c}};
    end else begin
      led_q <= '0;
    end
  end

  assign led_o    = led_q;
  assign active_o = active_c;

endmodule
